// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: shared types for the display-board shift register controllers
package shiftreg_pkg;

    // Transmit sequencer phases: idle, serial clock low, serial clock high, storage latch
    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } sr_state_t;

endpackage

// File: rtl/shiftreg_writer.sv
// shiftreg_writer: shifts a parallel word MSB-first into a 74HC595-class register and latches it
module shiftreg_writer
    import shiftreg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CLKDIV = 8
) (
    input  logic             clock_50m,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             busy,
    output logic             done,
    output logic             shiftreg_clk,
    output logic             shiftreg_data,
    output logic             shiftreg_latch
);

    localparam int HW = $clog2(CLKDIV + 1);
    localparam int BW = $clog2(WIDTH + 1);

    sr_state_t        state, next_state;
    logic [HW-1:0]    half_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_q;
    logic             accept, half_end, last_bit;
    logic             clk_d, latch_d, done_d;

    assign load_ready    = state == IDLE;
    assign busy          = !load_ready;
    assign accept        = load_valid && load_ready;
    assign half_end      = half_cnt == '0;
    assign last_bit      = bit_cnt == BW'(1);
    assign shiftreg_data = shift_q[WIDTH-1];

    // State register
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next state: every non-idle phase lasts exactly one half-period
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     next_state = accept ? SHIFT_LO : IDLE;
            SHIFT_LO: next_state = half_end ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI: next_state = half_end ? (last_bit ? LATCH : SHIFT_LO) : SHIFT_HI;
            LATCH:    next_state = half_end ? IDLE : LATCH;
            default:  next_state = IDLE;
        endcase
    end

    // Output decode from the next state so the pins flip on the same edge as the state
    always_comb begin
        clk_d   = next_state == SHIFT_HI;
        latch_d = next_state == LATCH;
        done_d  = state == LATCH && next_state == IDLE;
    end

    // Pin registers keep the board-facing signals glitch-free
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) begin
            shiftreg_clk   <= 1'b0;
            shiftreg_latch <= 1'b0;
            done           <= 1'b0;
        end else begin
            shiftreg_clk   <= clk_d;
            shiftreg_latch <= latch_d;
            done           <= done_d;
        end
    end

    // Half-period timer reloads whenever the phase changes
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n)                 half_cnt <= '0;
        else if (next_state != state) half_cnt <= HW'(CLKDIV - 1);
        else if (!half_end)           half_cnt <= half_cnt - HW'(1);
    end

    // Word capture and MSB-first shifting; data only moves on the high-to-low transition
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (accept) begin
            bit_cnt <= BW'(WIDTH);
            shift_q <= data_in;
        end else if (state == SHIFT_HI && half_end) begin
            bit_cnt <= bit_cnt - BW'(1);
            if (!last_bit) shift_q <= shift_q << 1;
        end
    end

endmodule
